// File: rtl/img_mem_arbiter.sv
// img_mem_arbiter: shares one single-port synchronous image memory between the
// display scanner and a host pixel writer. The scanner always wins. Because the
// scanner repeats each pixel horizontally, a read of the same address as the
// previous cycle is answered from the held output pixel. That frees the memory
// slot so a posted write can be committed instead.
module img_mem_arbiter #(
    parameter int AW            = 17,
    parameter int DW            = 24,
    parameter int FIFO_DEPTH    = 4,
    parameter int WR_BLANK_ONLY = 0
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          scan_req,
    input  logic [AW-1:0] scan_addr,
    output logic          pix_valid,
    output logic [DW-1:0] pix_data,
    input  logic          wr_valid,
    output logic          wr_ready,
    input  logic [AW-1:0] wr_addr,
    input  logic [DW-1:0] wr_data,
    output logic          mem_en,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata
);
    localparam int   PW           = $clog2(FIFO_DEPTH);
    localparam logic ALLOW_HIT_WR = (WR_BLANK_ONLY == 0);

    // Posted-write FIFO storage. The pointers carry one extra wrap bit.
    logic [AW-1:0] r_fifo_addr [FIFO_DEPTH];
    logic [DW-1:0] r_fifo_data [FIFO_DEPTH];
    logic [PW:0]   r_wr_ptr;
    logic [PW:0]   r_rd_ptr;
    logic          r_wr_ready;

    // Repeat-detection state: the previous scan request and its address.
    logic          r_prev_req;
    logic [AW-1:0] r_prev_addr;
    logic          r_hold_ok;

    // Read pipeline tags. "miss" marks requests that really read the memory.
    logic          r_s1_req;
    logic          r_s1_miss;
    logic          r_s2_req;
    logic          r_s2_miss;

    logic          r_mem_en;
    logic          r_mem_we;
    logic [AW-1:0] r_mem_addr;
    logic [DW-1:0] r_mem_wdata;
    logic          r_pix_valid;
    logic [DW-1:0] r_pix_data;

    logic          w_empty;
    logic          w_push;
    logic          w_hit;
    logic          w_miss;
    logic          w_free;
    logic          w_grant;
    logic [AW-1:0] w_head_addr;
    logic [DW-1:0] w_head_data;
    logic [PW:0]   w_wr_ptr_next;
    logic [PW:0]   w_rd_ptr_next;
    logic          w_full_next;

    assign w_empty     = (r_wr_ptr == r_rd_ptr);
    assign w_push      = wr_valid & r_wr_ready;
    assign w_hit       = scan_req & r_prev_req & (scan_addr == r_prev_addr) & r_hold_ok;
    assign w_miss      = scan_req & ~w_hit;
    assign w_free      = ~scan_req | (w_hit & ALLOW_HIT_WR);
    assign w_grant     = w_free & ~w_empty;
    assign w_head_addr = r_fifo_addr[r_rd_ptr[PW-1:0]];
    assign w_head_data = r_fifo_data[r_rd_ptr[PW-1:0]];

    assign w_wr_ptr_next = r_wr_ptr + {{PW{1'b0}}, w_push};
    assign w_rd_ptr_next = r_rd_ptr + {{PW{1'b0}}, w_grant};
    assign w_full_next   = (w_wr_ptr_next[PW-1:0] == w_rd_ptr_next[PW-1:0]) &
                           (w_wr_ptr_next[PW] != w_rd_ptr_next[PW]);

    // FIFO payload write. Storage needs no reset because the pointers define validity.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_fifo_addr[r_wr_ptr[PW-1:0]] <= wr_addr;
            r_fifo_data[r_wr_ptr[PW-1:0]] <= wr_data;
        end
    end

    // FIFO pointers and registered ready. There is no pop-to-push bypass.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_wr_ready <= 1'b0;
        end else begin
            r_wr_ptr   <= w_wr_ptr_next;
            r_rd_ptr   <= w_rd_ptr_next;
            r_wr_ready <= ~w_full_next;
        end
    end

    // Repeat tracking. The hold is dropped when a granted write hits the held address.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_prev_req  <= 1'b0;
            r_prev_addr <= '0;
            r_hold_ok   <= 1'b0;
        end else begin
            r_prev_req  <= scan_req;
            r_prev_addr <= scan_addr;
            r_hold_ok   <= scan_req & ~(w_grant & (w_head_addr == r_prev_addr));
        end
    end

    // Memory command stage: a scan miss reads, a free slot commits the FIFO head.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_mem_en    <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
        end else if (w_grant) begin
            r_mem_en    <= 1'b1;
            r_mem_we    <= 1'b1;
            r_mem_addr  <= w_head_addr;
            r_mem_wdata <= w_head_data;
        end else begin
            r_mem_en <= w_miss;
            r_mem_we <= 1'b0;
            if (w_miss) begin
                r_mem_addr <= scan_addr;
            end
        end
    end

    // Fixed 3-cycle return path. On a hit, pix_data simply keeps the repeated pixel.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s1_req    <= 1'b0;
            r_s1_miss   <= 1'b0;
            r_s2_req    <= 1'b0;
            r_s2_miss   <= 1'b0;
            r_pix_valid <= 1'b0;
            r_pix_data  <= '0;
        end else begin
            r_s1_req    <= scan_req;
            r_s1_miss   <= w_miss;
            r_s2_req    <= r_s1_req;
            r_s2_miss   <= r_s1_miss;
            r_pix_valid <= r_s2_req;
            if (r_s2_miss) begin
                r_pix_data <= mem_rdata;
            end
        end
    end

    assign wr_ready  = r_wr_ready;
    assign mem_en    = r_mem_en;
    assign mem_we    = r_mem_we;
    assign mem_addr  = r_mem_addr;
    assign mem_wdata = r_mem_wdata;
    assign pix_valid = r_pix_valid;
    assign pix_data  = r_pix_data;

endmodule

// File: tb/tb_img_mem_arbiter.sv
// Bench for img_mem_arbiter.
// Instance A (hit-slot writes allowed) is checked every cycle against a
// reference model. The model keeps a shadow image, a queue of posted writes,
// and the expected pixel stream.
// Instance B (blank-only writes) is driven through a short hand-written sequence.
module tb_img_mem_arbiter;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        scan_req = 1'b0;
    logic [16:0] scan_addr = '0;
    logic        wr_valid = 1'b0;
    logic [16:0] wr_addr = '0;
    logic [23:0] wr_data = '0;
    logic        pix_valid, wr_ready, mem_en, mem_we;
    logic [23:0] pix_data, mem_wdata, mem_rdata;
    logic [16:0] mem_addr;

    logic        b_scan_req = 1'b0;
    logic [16:0] b_scan_addr = '0;
    logic        b_wr_valid = 1'b0;
    logic [16:0] b_wr_addr = '0;
    logic [23:0] b_wr_data = '0;
    logic        b_pix_valid, b_wr_ready, b_mem_en, b_mem_we;
    logic [23:0] b_pix_data, b_mem_wdata, b_mem_rdata;
    logic [16:0] b_mem_addr;

    always #5 clk = ~clk;

    img_mem_arbiter #(.AW(17), .DW(24), .FIFO_DEPTH(4), .WR_BLANK_ONLY(0)) dut_a (
        .clk(clk), .rst(rst), .scan_req(scan_req), .scan_addr(scan_addr),
        .pix_valid(pix_valid), .pix_data(pix_data), .wr_valid(wr_valid),
        .wr_ready(wr_ready), .wr_addr(wr_addr), .wr_data(wr_data),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    img_mem_arbiter #(.AW(17), .DW(24), .FIFO_DEPTH(4), .WR_BLANK_ONLY(1)) dut_b (
        .clk(clk), .rst(rst), .scan_req(b_scan_req), .scan_addr(b_scan_addr),
        .pix_valid(b_pix_valid), .pix_data(b_pix_data), .wr_valid(b_wr_valid),
        .wr_ready(b_wr_ready), .wr_addr(b_wr_addr), .wr_data(b_wr_data),
        .mem_en(b_mem_en), .mem_we(b_mem_we), .mem_addr(b_mem_addr),
        .mem_wdata(b_mem_wdata), .mem_rdata(b_mem_rdata)
    );

    // Power-up image contents; address 77 is preset for the overwrite test.
    function automatic logic [23:0] init_pix(input logic [16:0] a);
        logic [31:0] t;
        if (a == 17'd77) return 24'h111111;
        t = (32'(a) * 32'd2654435) ^ 32'h00A5C396;
        return t[23:0];
    endfunction

    // Synchronous single-port memory models, one per instance.
    logic [23:0] ma_store [131072];
    bit          ma_wr    [131072];
    logic [23:0] mb_store [131072];
    bit          mb_wr    [131072];

    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) begin
                ma_store[mem_addr] <= mem_wdata;
                ma_wr[mem_addr]    <= 1'b1;
            end else begin
                mem_rdata <= ma_wr[mem_addr] ? ma_store[mem_addr] : init_pix(mem_addr);
            end
        end
    end

    always @(posedge clk) begin
        if (b_mem_en) begin
            if (b_mem_we) begin
                mb_store[b_mem_addr] <= b_mem_wdata;
                mb_wr[b_mem_addr]    <= 1'b1;
            end else begin
                b_mem_rdata <= mb_wr[b_mem_addr] ? mb_store[b_mem_addr] : init_pix(b_mem_addr);
            end
        end
    end

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s act=%0h exp=%0h", nm, act, exp);
        end
    endtask

    // ---------------- reference model for instance A ----------------
    typedef struct packed { logic [16:0] a; logic [23:0] d; } wr_t;
    typedef struct packed { logic v; logic [23:0] d; } px_t;

    wr_t         wq[$];
    px_t         pq[$];
    logic [23:0] shadow [131072];
    bit          m_prev_req, m_hold_ok, m_ready;
    logic [16:0] m_prev_addr;
    logic [23:0] m_last;
    bit          e_en, e_we;
    logic [16:0] e_addr;
    logic [23:0] e_wdata;
    int          n_grants = 0;

    task automatic model_reset();
        wq.delete();
        pq.delete();
        pq.push_back('0);
        pq.push_back('0);
        m_prev_req = 0;
        m_hold_ok  = 0;
        m_ready    = 0;
        m_last     = '0;
    endtask

    // Apply the current inputs as one scheduling cycle.
    task automatic model_cycle();
        bit  hit, free, grant, push;
        wr_t h;
        px_t p;
        hit   = scan_req && m_prev_req && (scan_addr == m_prev_addr) && m_hold_ok;
        free  = !scan_req || hit;
        grant = free && (wq.size() > 0);
        push  = wr_valid && m_ready;
        e_we  = grant;
        e_en  = grant || (scan_req && !hit);
        if (scan_req) begin
            m_last = shadow[scan_addr];
            e_addr = scan_addr;
        end
        p.v = scan_req;
        p.d = m_last;
        pq.push_back(p);
        h = '0;
        if (grant) begin
            h = wq.pop_front();
            shadow[h.a] = h.d;
            e_addr  = h.a;
            e_wdata = h.d;
            n_grants++;
            $display("commit addr=%0d data=%06h", h.a, h.d);
        end
        m_hold_ok   = scan_req && !(grant && (h.a == m_prev_addr));
        m_prev_req  = scan_req;
        m_prev_addr = scan_addr;
        if (push) begin
            h.a = wr_addr;
            h.d = wr_data;
            wq.push_back(h);
        end
        m_ready = (wq.size() < 4);
    endtask

    task automatic check_a();
        px_t p;
        p = pq.pop_front();
        chk("mem_en", 32'(mem_en), 32'(e_en));
        chk("mem_we", 32'(mem_we), 32'(e_we));
        if (e_en) chk("mem_addr", 32'(mem_addr), 32'(e_addr));
        if (e_we) chk("mem_wdata", 32'(mem_wdata), 32'(e_wdata));
        chk("wr_ready", 32'(wr_ready), 32'(m_ready));
        chk("pix_valid", 32'(pix_valid), 32'(p.v));
        chk("pix_data", 32'(pix_data), 32'(p.d));
    endtask

    // One cycle on instance A: drive at the falling edge, check at the next falling edge.
    task automatic step(input bit rq, input logic [16:0] ad, input bit wv,
                        input logic [16:0] wa, input logic [23:0] wd);
        scan_req  = rq;
        scan_addr = ad;
        wr_valid  = wv;
        wr_addr   = wa;
        wr_data   = wd;
        model_cycle();
        @(posedge clk);
        @(negedge clk);
        check_a();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        scan_req = 1'b0;
        wr_valid = 1'b0;
        #1;
        chk("rst_mem_en", 32'(mem_en), 32'd0);
        chk("rst_mem_we", 32'(mem_we), 32'd0);
        chk("rst_pix_valid", 32'(pix_valid), 32'd0);
        chk("rst_wr_ready", 32'(wr_ready), 32'd0);
        chk("rst_mem_addr", 32'(mem_addr), 32'd0);
        chk("rst_pix_data", 32'(pix_data), 32'd0);
        chk("rst_b_mem_we", 32'(b_mem_we), 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        model_reset();
    endtask

    task automatic step_b(input bit rq, input logic [16:0] ad, input bit wv,
                          input logic [16:0] wa, input logic [23:0] wd);
        b_scan_req  = rq;
        b_scan_addr = ad;
        b_wr_valid  = wv;
        b_wr_addr   = wa;
        b_wr_data   = wd;
        @(posedge clk);
        @(negedge clk);
    endtask

    typedef struct { bit rq; logic [16:0] a; bit en; bit pv; logic [23:0] pd; } vec_t;
    vec_t vt [15];

    initial begin
        int          k, g0, rep_left, blank_left, line_left;
        bit          acc, ofr_v, rq;
        logic [16:0] cur, ofr_a;
        logic [23:0] ofr_d;

        // Scan 0,0,0,0,1,1,1,1,2,2,2,2 then idle, with no writes.
        vt[0]  = '{1'b1, 17'd0, 1'b1, 1'b0, 24'h0};
        vt[1]  = '{1'b1, 17'd0, 1'b0, 1'b0, 24'h0};
        vt[2]  = '{1'b1, 17'd0, 1'b0, 1'b1, init_pix(17'd0)};
        vt[3]  = '{1'b1, 17'd0, 1'b0, 1'b1, init_pix(17'd0)};
        vt[4]  = '{1'b1, 17'd1, 1'b1, 1'b1, init_pix(17'd0)};
        vt[5]  = '{1'b1, 17'd1, 1'b0, 1'b1, init_pix(17'd0)};
        vt[6]  = '{1'b1, 17'd1, 1'b0, 1'b1, init_pix(17'd1)};
        vt[7]  = '{1'b1, 17'd1, 1'b0, 1'b1, init_pix(17'd1)};
        vt[8]  = '{1'b1, 17'd2, 1'b1, 1'b1, init_pix(17'd1)};
        vt[9]  = '{1'b1, 17'd2, 1'b0, 1'b1, init_pix(17'd1)};
        vt[10] = '{1'b1, 17'd2, 1'b0, 1'b1, init_pix(17'd2)};
        vt[11] = '{1'b1, 17'd2, 1'b0, 1'b1, init_pix(17'd2)};
        vt[12] = '{1'b0, 17'd0, 1'b0, 1'b1, init_pix(17'd2)};
        vt[13] = '{1'b0, 17'd0, 1'b0, 1'b1, init_pix(17'd2)};
        vt[14] = '{1'b0, 17'd0, 1'b0, 1'b0, init_pix(17'd2)};

        for (int i = 0; i < 131072; i++) shadow[i] = init_pix(17'(i));

        @(negedge clk);
        do_reset();

        // Pixel repeat without writes: table-driven.
        for (int i = 0; i < 15; i++) begin
            step(vt[i].rq, vt[i].a, 1'b0, '0, '0);
            chk("t1_mem_en", 32'(mem_en), 32'(vt[i].en));
            chk("t1_pix_valid", 32'(pix_valid), 32'(vt[i].pv));
            chk("t1_pix_data", 32'(pix_data), 32'(vt[i].pd));
        end

        // Writes committed in repeat-hit slots while scanning.
        k = 0;
        g0 = n_grants;
        for (int c = 0; c < 16; c++) begin
            acc = (k < 4) && m_ready;
            step(1'b1, 17'(c / 4), k < 4, 17'(500 + k), 24'hB00000 + 24'(k));
            if (acc) k++;
        end
        chk("t2_accepted", 32'(k), 32'd4);
        chk("t2_commits", 32'(n_grants - g0), 32'd4);
        for (int c = 0; c < 4; c++) step(1'b1, 17'(500 + c), 1'b0, '0, '0);
        for (int c = 0; c < 3; c++) step(1'b0, '0, 1'b0, '0, '0);

        // All-distinct scan fills the FIFO; the blanking interval drains it.
        k = 0;
        g0 = n_grants;
        for (int c = 0; c < 12; c++) begin
            acc = (k < 6) && m_ready;
            step(1'b1, 17'(200 + c), k < 6, 17'(300 + k), 24'hC00000 + 24'(k));
            if (acc) k++;
        end
        chk("t3_accepted_full", 32'(k), 32'd4);
        chk("t3_no_commit", 32'(n_grants - g0), 32'd0);
        for (int c = 0; c < 10; c++) begin
            acc = (k < 6) && m_ready;
            step(1'b0, '0, k < 6, 17'(300 + k), 24'hC00000 + 24'(k));
            if (acc) k++;
        end
        chk("t3_commits", 32'(n_grants - g0), 32'd6);
        for (int c = 0; c < 6; c++) step(1'b1, 17'(300 + c), 1'b0, '0, '0);
        for (int c = 0; c < 3; c++) step(1'b0, '0, 1'b0, '0, '0);

        // Overwrite the pixel currently being repeated.
        k = 0;
        for (int c = 0; c < 16; c++) begin
            acc = (c >= 1) && (k < 1) && m_ready;
            step(1'b1, 17'd77, (c >= 1) && (k < 1), 17'd77, 24'h222222);
            if (acc) k++;
            if (c == 2) chk("t4_old_pixel", 32'(pix_data), 32'h111111);
        end
        for (int c = 0; c < 3; c++) step(1'b0, '0, 1'b0, '0, '0);
        chk("t4_new_pixel", 32'(pix_data), 32'h222222);

        // Reset while writes are pending and one write is in flight.
        k = 0;
        for (int c = 0; c < 4; c++) begin
            acc = m_ready;
            step(1'b1, 17'(1000 + c), 1'b1, 17'(600 + k), 24'hD00000 + 24'(k));
            if (acc) k++;
        end
        step(1'b0, '0, 1'b0, '0, '0);
        chk("t5_we_before_rst", 32'(mem_we), 32'd1);
        do_reset();
        g0 = n_grants;
        for (int c = 0; c < 8; c++) step(1'b0, '0, 1'b0, '0, '0);
        chk("t5_we_after_rst", 32'(mem_we), 32'd0);

        // Randomized scan lines, repeats, blanking and writes.
        rep_left = 0;
        blank_left = 0;
        line_left = 20;
        cur = '0;
        ofr_v = 0;
        ofr_a = '0;
        ofr_d = '0;
        for (int c = 0; c < 1500; c++) begin
            if (blank_left > 0) begin
                rq = 1'b0;
                blank_left--;
            end else begin
                if (rep_left == 0) begin
                    cur = 17'($urandom_range(0, 31));
                    rep_left = int'($urandom_range(1, 4));
                end
                rq = 1'b1;
                rep_left--;
                line_left--;
                if (line_left == 0) begin
                    blank_left = int'($urandom_range(1, 6));
                    line_left = int'($urandom_range(8, 40));
                end
            end
            if (!ofr_v && ($urandom_range(0, 1) == 1)) begin
                ofr_v = 1'b1;
                ofr_a = 17'($urandom_range(0, 31));
                ofr_d = 24'($urandom);
            end
            acc = ofr_v && m_ready;
            step(rq, cur, ofr_v, ofr_a, ofr_d);
            if (acc) ofr_v = 1'b0;
        end
        for (int c = 0; c < 8; c++) step(1'b0, '0, 1'b0, '0, '0);

        // Blank-only instance: writes wait for scan_req=0.
        chk("t6_ready", 32'(b_wr_ready), 32'd1);
        step_b(1'b1, 17'd10, 1'b1, 17'd20, 24'h0A0A0A);
        chk("t6_first_read_en", 32'(b_mem_en), 32'd1);
        chk("t6_we_c0", 32'(b_mem_we), 32'd0);
        step_b(1'b1, 17'd10, 1'b1, 17'd21, 24'h0B0B0B);
        chk("t6_we_c1", 32'(b_mem_we), 32'd0);
        for (int c = 2; c < 8; c++) begin
            step_b(1'b1, 17'd10, 1'b0, '0, '0);
            chk("t6_we_scan", 32'(b_mem_we), 32'd0);
            if (c == 2) chk("t6_pix10", 32'(b_pix_data), 32'(init_pix(17'd10)));
        end
        step_b(1'b0, '0, 1'b0, '0, '0);
        chk("t6_we_blank0", 32'(b_mem_we), 32'd1);
        chk("t6_addr_blank0", 32'(b_mem_addr), 32'd20);
        chk("t6_data_blank0", 32'(b_mem_wdata), 32'h0A0A0A);
        step_b(1'b0, '0, 1'b0, '0, '0);
        chk("t6_we_blank1", 32'(b_mem_we), 32'd1);
        chk("t6_addr_blank1", 32'(b_mem_addr), 32'd21);
        step_b(1'b0, '0, 1'b0, '0, '0);
        chk("t6_we_blank2", 32'(b_mem_we), 32'd0);
        step_b(1'b1, 17'd20, 1'b0, '0, '0);
        step_b(1'b1, 17'd21, 1'b0, '0, '0);
        step_b(1'b0, '0, 1'b0, '0, '0);
        chk("t6_read20_valid", 32'(b_pix_valid), 32'd1);
        chk("t6_read20", 32'(b_pix_data), 32'h0A0A0A);
        step_b(1'b0, '0, 1'b0, '0, '0);
        chk("t6_read21", 32'(b_pix_data), 32'h0B0B0B);
        step_b(1'b0, '0, 1'b0, '0, '0);
        chk("t6_idle_valid", 32'(b_pix_valid), 32'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
